// File: rtl/bomba_controle.sv
// Time-bomb game sequencer: fuse countdown, 4-digit defuse code entry,
// wrong-code penalties and the defused/exploded outcome.
module bomba_controle #(
  parameter int          TEMPO_INICIAL = 60,
  parameter logic [15:0] SENHA         = 16'h1234,
  parameter int          MAX_ERROS     = 3,
  parameter int          PENALIDADE    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       armar,
  input  logic [9:0] tempo_cfg,
  input  logic [3:0] digito,
  input  logic       entrada_ok,
  output logic [9:0] tempo_restante,
  output logic [1:0] digitos_lidos,
  output logic [2:0] erros,
  output logic [1:0] estado,
  output logic       bip,
  output logic       explodiu,
  output logic       desarmada
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMADA    = 2'b01,
    DESARMADA = 2'b10,
    EXPLODIU  = 2'b11
  } estado_t;

  estado_t     r_estado;
  logic [9:0]  r_tempo;
  logic [1:0]  r_digitos;
  logic [2:0]  r_erros;
  logic [11:0] r_buf;
  logic        r_bip;
  logic        r_explodiu;
  logic        r_desarmada;

  logic        w_dig_valido;
  logic        w_quarto;
  logic        w_acerto;
  logic        w_erro;
  logic [10:0] w_desconto;
  logic [10:0] w_tempo_ext;
  logic [9:0]  w_tempo_novo;
  logic [2:0]  w_erros_novo;
  logic [9:0]  w_carga;
  logic        w_explode;

  // Tick and penalty are folded into one saturating subtraction so a wrong
  // code landing on a tick costs PENALIDADE+1 without ever wrapping below 0.
  always_comb begin
    w_dig_valido = entrada_ok && (digito <= 4'd9);
    w_quarto     = w_dig_valido && (r_digitos == 2'd3);
    w_acerto     = w_quarto && ({r_buf, digito} == SENHA);
    w_erro       = w_quarto && !w_acerto;
    w_desconto   = (tick_1s ? 11'd1 : 11'd0) + (w_erro ? 11'(PENALIDADE) : 11'd0);
    w_tempo_ext  = {1'b0, r_tempo};
    w_tempo_novo = (w_tempo_ext > w_desconto) ? 10'(w_tempo_ext - w_desconto) : 10'd0;
    w_erros_novo = (w_erro && (r_erros < 3'(MAX_ERROS))) ? r_erros + 3'd1 : r_erros;
    w_explode    = (w_tempo_novo == 10'd0) ||
                   (w_erro && (w_erros_novo == 3'(MAX_ERROS)));
    if (tempo_cfg == 10'd0)
      w_carga = 10'(TEMPO_INICIAL);
    else if (tempo_cfg > 10'd999)
      w_carga = 10'd999;
    else
      w_carga = tempo_cfg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado    <= IDLE;
      r_tempo     <= 10'd0;
      r_digitos   <= 2'd0;
      r_erros     <= 3'd0;
      r_buf       <= 12'd0;
      r_bip       <= 1'b0;
      r_explodiu  <= 1'b0;
      r_desarmada <= 1'b0;
    end else begin
      r_bip <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (armar) begin
            r_estado  <= ARMADA;
            r_tempo   <= w_carga;
            r_digitos <= 2'd0;
            r_erros   <= 3'd0;
            r_buf     <= 12'd0;
          end
        end

        ARMADA: begin
          if (w_acerto) begin
            // A correct code beats a simultaneous tick: time freezes as-is.
            r_estado    <= DESARMADA;
            r_desarmada <= 1'b1;
            r_digitos   <= 2'd0;
            r_buf       <= 12'd0;
          end else begin
            r_tempo <= w_tempo_novo;
            r_erros <= w_erros_novo;
            r_bip   <= tick_1s;
            if (w_quarto) begin
              r_digitos <= 2'd0;
              r_buf     <= 12'd0;
            end else if (w_dig_valido) begin
              r_digitos <= r_digitos + 2'd1;
              r_buf     <= {r_buf[7:0], digito};
            end
            if ((tick_1s || w_erro) && w_explode) begin
              r_estado   <= EXPLODIU;
              r_explodiu <= 1'b1;
            end
          end
        end

        DESARMADA, EXPLODIU: begin
          if (armar) begin
            r_estado    <= IDLE;
            r_tempo     <= 10'd0;
            r_digitos   <= 2'd0;
            r_erros     <= 3'd0;
            r_buf       <= 12'd0;
            r_explodiu  <= 1'b0;
            r_desarmada <= 1'b0;
          end
        end

        default: r_estado <= IDLE;
      endcase
    end
  end

  assign tempo_restante = r_tempo;
  assign digitos_lidos  = r_digitos;
  assign erros          = r_erros;
  assign estado         = r_estado;
  assign bip            = r_bip;
  assign explodiu       = r_explodiu;
  assign desarmada      = r_desarmada;

endmodule

// File: tb/tb_bomba_controle.sv
// Directed bench for bomba_controle: countdown, defuse, penalties, races,
// invalid digits, clamping and asynchronous reset.
module tb_bomba_controle;

  logic       clk;
  logic       reset;
  logic       tick_1s;
  logic       armar;
  logic [9:0] tempo_cfg;
  logic [3:0] digito;
  logic       entrada_ok;
  logic [9:0] tempo_restante;
  logic [1:0] digitos_lidos;
  logic [2:0] erros;
  logic [1:0] estado;
  logic       bip;
  logic       explodiu;
  logic       desarmada;

  int tests_run = 0;
  int tests_failed = 0;

  bomba_controle dut (
    .clk            (clk),
    .reset          (reset),
    .tick_1s        (tick_1s),
    .armar          (armar),
    .tempo_cfg      (tempo_cfg),
    .digito         (digito),
    .entrada_ok     (entrada_ok),
    .tempo_restante (tempo_restante),
    .digitos_lidos  (digitos_lidos),
    .erros          (erros),
    .estado         (estado),
    .bip            (bip),
    .explodiu       (explodiu),
    .desarmada      (desarmada)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock with the given 1-cycle pulses; outputs are checked 1ns after the edge.
  task automatic step(input logic a, input logic t, input logic e, input logic [3:0] d);
    armar = a; tick_1s = t; entrada_ok = e; digito = d;
    @(posedge clk);
    #1;
    armar = 1'b0; tick_1s = 1'b0; entrada_ok = 1'b0; digito = 4'd0;
  endtask

  task automatic arm(input logic [9:0] cfg);
    tempo_cfg = cfg;
    step(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic three_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    step(1'b0, 1'b0, 1'b1, a);
    step(1'b0, 1'b0, 1'b1, b);
    step(1'b0, 1'b0, 1'b1, c);
  endtask

  initial begin
    reset = 1'b1; tick_1s = 1'b0; armar = 1'b0; tempo_cfg = 10'd0;
    digito = 4'd0; entrada_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_estado", 32'(estado), 0);
    chk("rst_tempo", 32'(tempo_restante), 0);
    chk("rst_flags", {29'd0, bip, explodiu, desarmada}, 0);

    // IDLE ignores ticks and digits
    step(1'b0, 1'b1, 1'b1, 4'd1);
    chk("idle_tempo", 32'(tempo_restante), 0);
    chk("idle_dig", 32'(digitos_lidos), 0);
    chk("idle_bip", 32'(bip), 0);

    // Countdown to explosion
    arm(10'd3);
    chk("cd_arm_estado", 32'(estado), 1);
    chk("cd_arm_tempo", 32'(tempo_restante), 3);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("cd_t2", 32'(tempo_restante), 2);
    chk("cd_bip1", 32'(bip), 1);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("cd_bip_low", 32'(bip), 0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("cd_t1", 32'(tempo_restante), 1);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("cd_t0", 32'(tempo_restante), 0);
    chk("cd_bip3", 32'(bip), 1);
    chk("cd_estado", 32'(estado), 3);
    chk("cd_explodiu", 32'(explodiu), 1);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("cd_no_bip", 32'(bip), 0);
    chk("cd_hold_tempo", 32'(tempo_restante), 0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("cd_back_idle", 32'(estado), 0);
    chk("cd_back_expl", 32'(explodiu), 0);

    // Defuse with default time
    arm(10'd0);
    chk("df_load60", 32'(tempo_restante), 60);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("df_t58", 32'(tempo_restante), 58);
    three_digits(4'd1, 4'd2, 4'd3);
    chk("df_dig3", 32'(digitos_lidos), 3);
    step(1'b0, 1'b0, 1'b1, 4'd4);
    chk("df_estado", 32'(estado), 2);
    chk("df_desarmada", 32'(desarmada), 1);
    chk("df_dig0", 32'(digitos_lidos), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0);
      chk("df_frozen", 32'(tempo_restante), 58);
      chk("df_no_bip", 32'(bip), 0);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("df_idle", 32'(estado), 0);
    chk("df_idle_des", 32'(desarmada), 0);

    // Penalties and error limit
    arm(10'd100);
    three_digits(4'd1, 4'd1, 4'd1);
    step(1'b0, 1'b0, 1'b1, 4'd1);
    chk("pn_t90", 32'(tempo_restante), 90);
    chk("pn_e1", 32'(erros), 1);
    chk("pn_armada", 32'(estado), 1);
    three_digits(4'd1, 4'd1, 4'd1);
    step(1'b0, 1'b0, 1'b1, 4'd1);
    chk("pn_t80", 32'(tempo_restante), 80);
    chk("pn_e2", 32'(erros), 2);
    three_digits(4'd1, 4'd1, 4'd1);
    step(1'b0, 1'b0, 1'b1, 4'd1);
    chk("pn_t70", 32'(tempo_restante), 70);
    chk("pn_e3", 32'(erros), 3);
    chk("pn_expl", 32'(estado), 3);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("pn_erros_clr", 32'(erros), 0);

    // Saturating penalty
    arm(10'd5);
    three_digits(4'd9, 4'd9, 4'd9);
    step(1'b0, 1'b0, 1'b1, 4'd9);
    chk("sat_tempo", 32'(tempo_restante), 0);
    chk("sat_estado", 32'(estado), 3);
    chk("sat_erros", 32'(erros), 1);
    step(1'b1, 1'b0, 1'b0, 4'd0);

    // Correct 4th digit and tick together
    arm(10'd1);
    three_digits(4'd1, 4'd2, 4'd3);
    step(1'b0, 1'b1, 1'b1, 4'd4);
    chk("race_ok_estado", 32'(estado), 2);
    chk("race_ok_tempo", 32'(tempo_restante), 1);
    chk("race_ok_bip", 32'(bip), 0);
    step(1'b1, 1'b0, 1'b0, 4'd0);

    // Wrong 4th digit and tick together
    arm(10'd20);
    three_digits(4'd1, 4'd1, 4'd1);
    step(1'b0, 1'b1, 1'b1, 4'd1);
    chk("race_bad_tempo", 32'(tempo_restante), 9);
    chk("race_bad_bip", 32'(bip), 1);
    chk("race_bad_erros", 32'(erros), 1);
    chk("race_bad_estado", 32'(estado), 1);

    // Invalid digits are dropped
    step(1'b0, 1'b0, 1'b1, 4'hA);
    chk("inv_A", 32'(digitos_lidos), 0);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    chk("inv_one", 32'(digitos_lidos), 1);
    step(1'b0, 1'b0, 1'b1, 4'hF);
    chk("inv_F", 32'(digitos_lidos), 1);
    step(1'b0, 1'b0, 1'b1, 4'd6);
    chk("inv_two", 32'(digitos_lidos), 2);

    // Asynchronous reset mid-entry, checked before the next clock edge
    #2 reset = 1'b1;
    #1;
    chk("arst_estado", 32'(estado), 0);
    chk("arst_tempo", 32'(tempo_restante), 0);
    chk("arst_dig", 32'(digitos_lidos), 0);
    chk("arst_erros", 32'(erros), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Clamp and armar ignored while armed
    arm(10'd1023);
    chk("clamp_999", 32'(tempo_restante), 999);
    chk("clamp_dig", 32'(digitos_lidos), 0);
    arm(10'd5);
    chk("rearm_ign_tempo", 32'(tempo_restante), 999);
    chk("rearm_ign_estado", 32'(estado), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bomba_controle.md
Name: bomba_controle

Overview:
- Top-level sequencer for the time-bomb game.
- Consumes the 1-cycle-per-second tick from the clock divider and counts the fuse time down.
- Accepts a 4-digit defuse code entered one digit at a time, applies time penalties for wrong codes, and decides the outcome: defused or exploded.
- Drives the display and LED logic through status outputs.

Parameters:
- TEMPO_INICIAL, 60: default fuse time in seconds when tempo_cfg is 0. Legal range 1..999.
- SENHA, 16'h1234: defuse code, 4 BCD digits, most significant digit entered first.
- MAX_ERROS, 3: number of wrong complete codes that causes an explosion. Legal range 1..7.
- PENALIDADE, 10: seconds subtracted per wrong code.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1s  in  1  1-cycle pulse once per second, from the divider
- armar  in  1  1-cycle pulse: arm from IDLE, or return to IDLE from DEFUSED/EXPLODED
- tempo_cfg  in  10  fuse time loaded on arm; 0 selects TEMPO_INICIAL; values >999 are clamped to 999
- digito  in  4  code digit, valid when entrada_ok=1
- entrada_ok  in  1  1-cycle pulse: digit entered
- tempo_restante  out  10  seconds remaining, binary
- digitos_lidos  out  2  digits accepted in the current code attempt (0..3)
- erros  out  3  wrong codes so far in this round
- estado  out  2  00 IDLE, 01 ARMADA, 10 DESARMADA, 11 EXPLODIU
- bip  out  1  1-cycle pulse on each accepted tick while ARMADA
- explodiu  out  1  high while in EXPLODIU
- desarmada  out  1  high while in DESARMADA

Behaviour:
- Reset (async, any state): estado=IDLE. tempo_restante, digitos_lidos, erros, internal digit buffer, bip, explodiu and desarmada are all 0.
- All inputs are synchronous, already debounced pulses. All outputs are registered, so effects appear one cycle after the triggering input edge.

IDLE:
- tick_1s, digito and entrada_ok are ignored; tempo_restante holds 0.
- On armar: load tempo_restante = (tempo_cfg==0 ? TEMPO_INICIAL : min(tempo_cfg,999)); clear erros, digitos_lidos and the buffer; go to ARMADA.

ARMADA, digit entry:
- On entrada_ok with digito > 9: the digit is ignored (no count change).
- On entrada_ok with a valid digit, when digitos_lidos < 3: shift the digit into the buffer and increment digitos_lidos.
- On the 4th valid digit: compare {buffer, digito} with SENHA, then clear the buffer and set digitos_lidos=0.
  - Match: go to DESARMADA; tempo_restante freezes at its current value.
  - Mismatch: erros+1 and tempo_restante -= PENALIDADE, saturating at 0.
  - If the new erros == MAX_ERROS, or tempo_restante reaches 0, go to EXPLODIU.

ARMADA, timer:
- On tick_1s: tempo_restante -= 1 and bip=1 for one cycle.
- If the result is 0, go to EXPLODIU on the same edge.

ARMADA, simultaneous events and other inputs:
- A correct 4th digit wins: go to DESARMADA, ignore that tick, no bip.
- A wrong 4th digit plus tick in the same cycle: subtract PENALIDADE+1, saturating at 0, and pulse bip. Explode if the result is 0 or the error limit is reached.
- armar in ARMADA is ignored; there is no abort except reset.

DESARMADA / EXPLODIU:
- Outputs hold; ticks and digits are ignored; bip=0.
- armar returns to IDLE: tempo_restante, erros and digitos_lidos clear to 0.

Widths:
- tempo_restante arithmetic uses 11-bit signed or compare-before-subtract, so there is never wrap-around below 0.
- erros saturates at MAX_ERROS.

Reset mid-operation:
- Immediate return to IDLE. No stale digits survive.

Test Plan:
- Countdown to explosion: reset; tempo_cfg=3, armar; 3 ticks -> tempo_restante 3→2→1→0, bip pulses after each tick, estado=11 and explodiu=1 after the third tick; further ticks give no bip.
- Defuse: tempo_cfg=0 (TEMPO_INICIAL=60), armar; 2 ticks (58); enter 1,2,3,4 -> estado=10, desarmada=1, tempo_restante frozen at 58 through 5 more ticks.
- Penalties and error limit: tempo_cfg=100, armar; wrong code 1,1,1,1 three times -> tempo 90, 80, then explode on the 3rd wrong code with erros=3, tempo_restante=70.
- Saturating penalty: tempo_cfg=5, armar; wrong code -> tempo_restante=0, estado=EXPLODIU, erros=1.
- Simultaneous events: tempo_cfg=1, armar; 4th correct digit and tick_1s in the same cycle -> DESARMADA, tempo_restante=1, no bip. Repeat with a wrong code plus tick at tempo 20 -> tempo_restante=9.
- Edge inputs and reset: digito=4'hA with entrada_ok -> digitos_lidos unchanged. tempo_cfg=1023 -> loads 999. Assert reset asynchronously mid-entry (digitos_lidos=2) -> all outputs 0 before the next clk edge. armar from EXPLODIU -> IDLE.
